// File: rtl/l1_trigger.sv
// L1 beam trigger: per-channel AGC energy, masked beam sums, threshold compare and windowed rate counting.
// Optional retrigger holdoff is enabled by defining L1_TRIGGER_HOLDOFF_EN.
module l1_trigger #(
    parameter int NBEAMS = 2,
    parameter int AGC_TIMESCALE_REDUCTION_BITS = 2,
    parameter int TRIGGER_CLOCKS = 375000000,
    parameter int HOLDOFF_CLOCKS = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [21:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_threshold_cyc_i,
    input  logic              wb_threshold_stb_i,
    input  logic              wb_threshold_we_i,
    input  logic [21:0]       wb_threshold_adr_i,
    input  logic [31:0]       wb_threshold_dat_i,
    input  logic [3:0]        wb_threshold_sel_i,
    output logic              wb_threshold_ack_o,
    output logic              wb_threshold_err_o,
    output logic              wb_threshold_rty_o,
    output logic [31:0]       wb_threshold_dat_o,
    input  logic [8*96-1:0]   dat_i,
    output logic [NBEAMS-1:0] trigger_o
);

    localparam int HW = (HOLDOFF_CLOCKS > 0) ? $clog2(HOLDOFF_CLOCKS + 1) : 1;

    logic [14:0]       energy_q [8];
    logic [14:0]       energy_d [8];
    logic [17:0]       sum_q [NBEAMS];
    logic [17:0]       sum_d [NBEAMS];
    logic [NBEAMS-1:0] trigger_q, trigger_d, rise;
    logic [HW-1:0]     hold_q [NBEAMS];
    logic [HW-1:0]     hold_d [NBEAMS];
    logic [17:0]       thr_q [NBEAMS];
    logic [17:0]       thr_d [NBEAMS];
    logic [7:0]        mask_q [NBEAMS];
    logic [7:0]        mask_d [NBEAMS];
    logic [31:0]       cnt_q [NBEAMS];
    logic [31:0]       cnt_d [NBEAMS];
    logic [31:0]       count_q [NBEAMS];
    logic [31:0]       count_d [NBEAMS];
    logic [31:0]       win_q, win_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [1:0]        ack_q, ack_d;
    logic [31:0]       rdat_q [2];
    logic [31:0]       rdat_d [2];

    logic [1:0]        acc, wr;
    logic [11:0]       adr [2];
    logic [31:0]       wdat [2];
    logic [3:0]        sel [2];
    logic [31:0]       rdata [2];
    logic              start;
    logic              unused_adr;

    // Index 1 is the control-loop port; it is processed last so it wins write collisions.
    assign adr[0]  = wb_adr_i[11:0];
    assign adr[1]  = wb_threshold_adr_i[11:0];
    assign wdat[0] = wb_dat_i;
    assign wdat[1] = wb_threshold_dat_i;
    assign sel[0]  = wb_sel_i;
    assign sel[1]  = wb_threshold_sel_i;
    assign acc[0]  = wb_cyc_i & wb_stb_i & ~ack_q[0];
    assign acc[1]  = wb_threshold_cyc_i & wb_threshold_stb_i & ~ack_q[1];
    assign wr[0]   = acc[0] & wb_we_i;
    assign wr[1]   = acc[1] & wb_threshold_we_i;
    assign unused_adr = ^{wb_adr_i[21:12], wb_threshold_adr_i[21:12]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        logic signed [11:0] smp;
        logic [11:0]        mag;
        logic [14:0]        abs_sum;
        smp = '0;
        mag = '0;
        abs_sum = '0;
        for (int c = 0; c < 8; c++) begin
            abs_sum = '0;
            for (int j = 0; j < 8; j++) begin
                smp = dat_i[c*96 + j*12 +: 12];
                // -2048 negates to 12'h800, which reads back as 2048 unsigned
                mag = smp[11] ? 12'(-smp) : 12'(smp);
                abs_sum = abs_sum + 15'(mag);
            end
            energy_d[c] = abs_sum >> AGC_TIMESCALE_REDUCTION_BITS;
        end
    end

    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            sum_d[b] = '0;
            for (int c = 0; c < 8; c++)
                if (mask_q[b][c]) sum_d[b] = sum_d[b] + 18'(energy_q[c]);
        end
    end

    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            trigger_d[b] = (sum_q[b] > thr_q[b]) && (hold_q[b] == '0);
`ifdef L1_TRIGGER_HOLDOFF_EN
            if (trigger_d[b])
                hold_d[b] = HW'(HOLDOFF_CLOCKS);
            else if (hold_q[b] != '0)
                hold_d[b] = hold_q[b] - HW'(1);
            else
                hold_d[b] = '0;
`else
            hold_d[b] = '0;
`endif
        end
        rise = trigger_d & ~trigger_q;
    end

    always_comb begin
        logic [31:0] merged;
        merged = '0;
        start  = 1'b0;
        thr_d  = thr_q;
        mask_d = mask_q;
        for (int p = 0; p < 2; p++) begin
            if (wr[p]) begin
                if (adr[p] == 12'h000 && sel[p][0] && wdat[p][0]) start = 1'b1;
                for (int b = 0; b < NBEAMS; b++) begin
                    if (adr[p] == 12'(12'h200 + b)) begin
                        merged = merge_bytes({14'b0, thr_d[b]}, wdat[p], sel[p]);
                        thr_d[b] = merged[17:0];
                    end
                    if (adr[p] == 12'(12'h400 + b)) begin
                        merged = merge_bytes({24'b0, mask_d[b]}, wdat[p], sel[p]);
                        mask_d[b] = merged[7:0];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (adr[p] == 12'h000) rdata[p] = {30'b0, busy_q, done_q};
            for (int b = 0; b < NBEAMS; b++) begin
                if (adr[p] == 12'(12'h100 + b)) rdata[p] = count_q[b];
                if (adr[p] == 12'(12'h200 + b)) rdata[p] = {14'b0, thr_q[b]};
                if (adr[p] == 12'(12'h400 + b)) rdata[p] = {24'b0, mask_q[b]};
            end
            ack_d[p]  = acc[p];
            rdat_d[p] = acc[p] ? rdata[p] : '0;
        end
    end

    // A start write takes priority over window expiry so a restart never latches counts.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            win_d  = 32'(TRIGGER_CLOCKS);
            for (int b = 0; b < NBEAMS; b++) cnt_d[b] = '0;
        end else if (busy_q) begin
            for (int b = 0; b < NBEAMS; b++)
                if (rise[b] && cnt_d[b] != '1) cnt_d[b] = cnt_d[b] + 32'd1;
            if (win_q <= 32'd1) begin
                count_d = cnt_d;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                win_d   = '0;
            end else begin
                win_d = win_q - 32'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int c = 0; c < 8; c++) energy_q[c] <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                sum_q[b]   <= '0;
                hold_q[b]  <= '0;
                thr_q[b]   <= 18'h3FFFF;
                mask_q[b]  <= 8'hFF;
                cnt_q[b]   <= '0;
                count_q[b] <= '0;
            end
            trigger_q <= '0;
            win_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= '0;
            rdat_q[0] <= '0;
            rdat_q[1] <= '0;
        end else begin
            energy_q  <= energy_d;
            sum_q     <= sum_d;
            hold_q    <= hold_d;
            thr_q     <= thr_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            trigger_q <= trigger_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
        end
    end

    assign trigger_o          = trigger_q;
    assign wb_ack_o           = ack_q[0];
    assign wb_dat_o           = rdat_q[0];
    assign wb_err_o           = 1'b0;
    assign wb_rty_o           = 1'b0;
    assign wb_threshold_ack_o = ack_q[1];
    assign wb_threshold_dat_o = rdat_q[1];
    assign wb_threshold_err_o = 1'b0;
    assign wb_threshold_rty_o = 1'b0;

endmodule

// File: tb/tb_l1_trigger.sv
// Self-checking bench for l1_trigger: directed register/trigger/window steps plus a randomized
// trigger phase checked against a sample-level beam-sum model.
module tb_l1_trigger;

    localparam int NB       = 2;
    localparam int AGC      = 2;
    localparam int HOLDOFF  = 16;
    localparam int WINDOW   = 100;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cyc [2];
    logic          stb [2];
    logic          we [2];
    logic [21:0]   adr [2];
    logic [31:0]   wdat [2];
    logic [3:0]    sel [2];
    logic          ack [2];
    logic          err [2];
    logic          rty [2];
    logic [31:0]   rdat [2];
    logic [767:0]  datIn;
    logic [NB-1:0] trig;

    int compared = 0;
    int mismatched = 0;

    logic [17:0] thrM [NB];
    logic [7:0]  maskM [NB];

    l1_trigger #(
        .NBEAMS(NB),
        .AGC_TIMESCALE_REDUCTION_BITS(AGC),
        .TRIGGER_CLOCKS(WINDOW),
        .HOLDOFF_CLOCKS(HOLDOFF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rstN),
        .wb_cyc_i(cyc[0]),
        .wb_stb_i(stb[0]),
        .wb_we_i(we[0]),
        .wb_adr_i(adr[0]),
        .wb_dat_i(wdat[0]),
        .wb_sel_i(sel[0]),
        .wb_ack_o(ack[0]),
        .wb_err_o(err[0]),
        .wb_rty_o(rty[0]),
        .wb_dat_o(rdat[0]),
        .wb_threshold_cyc_i(cyc[1]),
        .wb_threshold_stb_i(stb[1]),
        .wb_threshold_we_i(we[1]),
        .wb_threshold_adr_i(adr[1]),
        .wb_threshold_dat_i(wdat[1]),
        .wb_threshold_sel_i(sel[1]),
        .wb_threshold_ack_o(ack[1]),
        .wb_threshold_err_o(err[1]),
        .wb_threshold_rty_o(rty[1]),
        .wb_threshold_dat_o(rdat[1]),
        .dat_i(datIn),
        .trigger_o(trig)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbXfer(input int p, input logic w, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w;
        adr[p] = {10'b0, a}; wdat[p] = d; sel[p] = s;
        tick();
        checkVal($sformatf("ack%0d", p), 32'(ack[p]), 32'd1);
        checkVal($sformatf("errRty%0d", p), {30'b0, err[p], rty[p]}, 32'd0);
        r = rdat[p];
        cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
        tick();
        checkVal($sformatf("ackDrop%0d", p), 32'(ack[p]), 32'd0);
    endtask

    task automatic wbWrite(input int p, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wbXfer(p, 1'b1, a, d, s, r);
    endtask

    task automatic readCheck(input int p, input logic [11:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        wbXfer(p, 1'b0, a, 32'd0, 4'h0, r);
        checkVal(tag, r, exp);
    endtask

    task automatic setCh(input int ch, input int val);
        for (int j = 0; j < 8; j++) datIn[ch*96 + j*12 +: 12] = 12'(val);
    endtask

    function automatic int chanEnergy(input int ch);
        int sum;
        logic signed [11:0] s;
        sum = 0;
        for (int j = 0; j < 8; j++) begin
            s = datIn[ch*96 + j*12 +: 12];
            sum += (int'(s) < 0) ? -int'(s) : int'(s);
        end
        return sum >> AGC;
    endfunction

    function automatic int beamSum(input logic [7:0] m);
        int s;
        s = 0;
        for (int c = 0; c < 8; c++) if (m[c]) s += chanEnergy(c);
        return s;
    endfunction

    task automatic pulseBeam0();
        setCh(0, -60);
        tick();
        setCh(0, 20);
        repeat (17) tick();
    endtask

    task automatic waitDone();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 200; i++) begin
            wbXfer(0, 1'b0, 12'h000, 32'd0, 4'h0, r);
            if (r[0]) break;
        end
        checkVal("doneStatus", r, 32'd1);
    endtask

    initial begin
        logic [NB-1:0] expT [200];
        int            lastRise [NB];
        int            highCnt, riseCnt, firstRise;
        logic          prev;
        logic [NB-1:0] e;

        rstN = 1'b0;
        datIn = '0;
        for (int p = 0; p < 2; p++) begin
            cyc[p] = 0; stb[p] = 0; we[p] = 0; adr[p] = '0; wdat[p] = '0; sel[p] = '0;
        end
        #2;
        checkVal("rstTrig", 32'(trig), 32'd0);
        checkVal("rstAcks", {30'b0, ack[1], ack[0]}, 32'd0);
        checkVal("rstDat0", rdat[0], 32'd0);
        checkVal("rstDat1", rdat[1], 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        tick();

        $display("[TB] register reset values");
        readCheck(0, 12'h200, 32'h0003FFFF, "thr0Port0");
        readCheck(1, 12'h200, 32'h0003FFFF, "thr0Port1");
        readCheck(0, 12'h201, 32'h0003FFFF, "thr1Port0");
        readCheck(1, 12'h400, 32'h000000FF, "mask0Port1");
        readCheck(0, 12'h000, 32'd0, "statusReset");
        readCheck(0, 12'h100, 32'd0, "count0Reset");
        readCheck(1, 12'h202, 32'd0, "beamOutOfRange");
        readCheck(0, 12'h300, 32'd0, "unmappedRead");

        $display("[TB] default thresholds never trigger");
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 64; k++) datIn[k*12 +: 12] = 12'($urandom_range(0, 4095));
            tick();
            checkVal("defaultNoTrig", 32'(trig), 32'd0);
        end
        datIn = '0;

        $display("[TB] threshold crossing and latency");
        wbWrite(0, 12'h200, 32'd100, 4'hF);
        wbWrite(1, 12'h400, 32'h01, 4'hF);
        setCh(0, 20);
        repeat (5) tick();
        checkVal("energy40Below", 32'(trig), 32'd0);
        setCh(0, -60);
        tick();
        tick();
        checkVal("latency2", 32'(trig[0]), 32'd0);
        tick();
        checkVal("latency3", 32'(trig), 32'b01);

        wbWrite(0, 12'h200, 32'd120, 4'hF);
        setCh(0, 60);
        repeat (20) tick();
        checkVal("thrEqual", 32'(trig[0]), 32'd0);
        datIn[11:0] = 12'd64;
        tick();
        tick();
        checkVal("thrPlus1Lat2", 32'(trig[0]), 32'd0);
        tick();
        checkVal("thrPlus1", 32'(trig[0]), 32'd1);

        $display("[TB] sustained level");
        setCh(0, 0);
        repeat (20) tick();
        highCnt = 0; riseCnt = 0; firstRise = -1; prev = 1'b0;
        setCh(0, 100);
        for (int i = 0; i < 60; i++) begin
            if (i == 40) setCh(0, 0);
            tick();
            if (trig[0]) highCnt++;
            if (trig[0] && !prev) begin
                riseCnt++;
                if (firstRise < 0) firstRise = i;
            end
            prev = trig[0];
        end
        checkVal("levelFirstRise", firstRise, 32'd2);
`ifdef L1_TRIGGER_HOLDOFF_EN
        checkVal("levelHighClocks", highCnt, 32'd3);
        checkVal("levelRises", riseCnt, 32'd3);
`else
        checkVal("levelHighClocks", highCnt, 32'd40);
        checkVal("levelRises", riseCnt, 32'd1);
`endif

        $display("[TB] byte enables and write collision");
        wbWrite(0, 12'h200, 32'h00012345, 4'hF);
        wbWrite(1, 12'h200, 32'hAAAAAAAA, 4'b0010);
        readCheck(0, 12'h200, 32'h0001AA45, "selMerge");
        wbWrite(0, 12'h210, 32'h0, 4'hF);
        readCheck(1, 12'h200, 32'h0001AA45, "unmappedWrite");
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 22'h201; wdat[0] = 32'h111; sel[0] = 4'hF;
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 22'h201; wdat[1] = 32'h222; sel[1] = 4'hF;
        tick();
        checkVal("bothAck", {30'b0, ack[1], ack[0]}, 32'b11);
        cyc[0] = 0; stb[0] = 0; we[0] = 0; cyc[1] = 0; stb[1] = 0; we[1] = 0;
        tick();
        readCheck(0, 12'h201, 32'h222, "collisionWinner");

        $display("[TB] randomized trigger phase");
        maskM[0] = 8'h0F;
        thrM[0]  = 18'd8192;
        maskM[1] = 8'($urandom_range(1, 255));
        thrM[1]  = 18'($countones(maskM[1]) * 2048);
        for (int b = 0; b < NB; b++) begin
            wbWrite($urandom_range(0, 1), 12'(12'h200 + b), {14'b0, thrM[b]}, 4'hF);
            wbWrite($urandom_range(0, 1), 12'(12'h400 + b), {24'b0, maskM[b]}, 4'hF);
            lastRise[b] = -1000;
        end
        datIn = '0;
        repeat (20) tick();
        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < 64; k++) datIn[k*12 +: 12] = 12'($urandom_range(0, 4095));
            for (int b = 0; b < NB; b++) begin
                e[b] = beamSum(maskM[b]) > int'(thrM[b]);
`ifdef L1_TRIGGER_HOLDOFF_EN
                e[b] = e[b] && (t - lastRise[b] > HOLDOFF);
`endif
                if (e[b]) lastRise[b] = t;
            end
            expT[t] = e;
            tick();
            if (t >= 2) checkVal($sformatf("randTrig@%0d", t), 32'(trig), 32'(expT[t-2]));
        end
        datIn = '0;

        $display("[TB] rate window");
        wbWrite(0, 12'h200, 32'd100, 4'hF);
        wbWrite(1, 12'h400, 32'h01, 4'hF);
        wbWrite(1, 12'h201, 32'h3FFFF, 4'hF);
        setCh(0, 20);
        repeat (20) tick();
        wbWrite(0, 12'h000, 32'h1, 4'hF);
        readCheck(0, 12'h000, 32'h2, "busyAfterStart");
        repeat (5) pulseBeam0();
        waitDone();
        readCheck(0, 12'h100, 32'd5, "count0Window");
        readCheck(1, 12'h101, 32'd0, "count1Window");

        wbWrite(1, 12'h000, 32'h1, 4'hF);
        repeat (2) pulseBeam0();
        wbWrite(0, 12'h000, 32'h1, 4'hF);
        readCheck(1, 12'h100, 32'd5, "countRetained");
        readCheck(1, 12'h000, 32'h2, "busyRestart");
        repeat (3) pulseBeam0();
        waitDone();
        readCheck(0, 12'h100, 32'd3, "countRestart");

        $display("[TB] reset mid-window");
        wbWrite(0, 12'h000, 32'h1, 4'hF);
        pulseBeam0();
        setCh(0, -60);
        repeat (4) tick();
        rstN = 1'b0;
        #1;
        checkVal("midRstTrig", 32'(trig), 32'd0);
        repeat (2) tick();
        rstN = 1'b1;
        setCh(0, 20);
        repeat (120) tick();
        readCheck(0, 12'h000, 32'd0, "noLatchStatus");
        readCheck(0, 12'h100, 32'd0, "noLatchCount");
        readCheck(1, 12'h200, 32'h3FFFF, "thrAfterReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l1_trigger.md
L1_TRIGGER -- requirements
Module: l1_trigger

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NBEAMS, default 2: number of beams and trigger outputs.
REQ-003 Parameter AGC_TIMESCALE_REDUCTION_BITS, default 2: right-shift applied to each channel energy.
REQ-004 Parameter TRIGGER_CLOCKS, default 375000000: rate-count window length in clocks.
REQ-005 Parameter HOLDOFF_CLOCKS, default 16: per-beam retrigger holdoff length.
REQ-006 Port wb_clk_i, input, 1 bit: the single clock for all logic.
REQ-007 Port wb_rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 Port bundle wb_ (general target), with widths as follows:
- inputs cyc, stb, we: 1 bit each;
- input adr: 22 bits;
- input dat: 32 bits;
- input sel: 4 bits;
- outputs ack, err, rty: 1 bit each;
- output dat: 32 bits.
REQ-009 Port bundle wb_threshold_ (control-loop target) SHALL have the same signals and widths as wb_.
REQ-010 Port dat_i, input, 8x96 bits: 8 channels, each carrying 8 signed 12-bit samples (sample 0 in bits [11:0]).
REQ-011 Port trigger_o, output, NBEAMS bits: per-beam trigger.

Function
REQ-012 Channel energy SHALL be the sum of |s| over the channel's 8 samples, right-shifted by AGC_TIMESCALE_REDUCTION_BITS.
- |-2048| = 2048.
- The unshifted sum is 15 bits unsigned.
REQ-013 Beam statistic S_b SHALL be the 18-bit unsigned sum of the energies of the channels enabled in mask_b[7:0].
REQ-014 trigger_o[b] SHALL be asserted when S_b > thr_b (strictly greater), registered, 3 clocks after dat_i is sampled.
REQ-015 Register map (same on both ports; decoded on adr[11:0]):
- 0x000 control/status: write bit0=1 starts a window; read returns bit0=done, bit1=busy.
- 0x100+b: count_b, read-only.
- 0x200+b: thr_b[17:0], read/write.
- 0x400+b: mask_b[7:0], read/write.
REQ-016 Unmapped reads and beam indices >= NBEAMS SHALL return 0; unmapped writes SHALL be ignored.
REQ-017 Writes SHALL honor sel byte enables.
REQ-018 Each port SHALL pulse ack for exactly one clock, one clock after cyc&stb are sampled high, and SHALL return read data with that ack; err and rty SHALL be 0.
REQ-019 If both ports write the same register in the same clock, the wb_threshold_ write SHALL win.
REQ-020 Start write: clear done, set busy, zero the internal counters, and load the window counter with TRIGGER_CLOCKS.
REQ-021 While busy, each beam SHALL count rising edges of trigger_o[b] in a 32-bit saturating counter.
REQ-022 When the window counter expires:
- count_b SHALL latch the internal counters;
- done SHALL be set and busy cleared in the same clock.
REQ-023 A start write while busy SHALL restart the window; the previously latched count_b values SHALL be retained.

Reset
REQ-024 Reset SHALL set:
- trigger_o=0, all acks=0, all dat outputs=0;
- thr_b=18'h3FFFF, mask_b=8'hFF;
- count_b=0, done=0, busy=0;
- pipeline and holdoff counters to 0.
REQ-025 Reset mid-window SHALL abort the window; no latch SHALL occur.

Configuration
REQ-026 The holdoff feature SHALL be controlled by macro L1_TRIGGER_HOLDOFF_EN.
- Defined: after trigger_o[b] rises, it SHALL be held low for the HOLDOFF_CLOCKS following clocks regardless of S_b, so each trigger is a one-clock pulse.
- Undefined: trigger_o[b] SHALL follow the comparison every clock.

Verification
REQ-027 After reset, read 0x200 on both ports -> 0x0003FFFF; read 0x000 -> 0; trigger_o=0 for all inputs.
REQ-028 Set thr_0=100 and mask_0=0x01; drive ch0 samples all +20 (energy 160>>2=40), then all -60 (energy 120) -> trigger_o[0] stays 0 for 40, then goes 1 three clocks after the -60 data.
REQ-029 Set thr_0=120 with S_0=120 -> trigger_o[0]=0; S_0=121 -> trigger_o[0]=1.
REQ-030 With TRIGGER_CLOCKS=100 and 5 isolated trigger pulses on beam 0 during the window:
- write 0x000=1 -> busy=1;
- poll until done=1 -> read 0x100 returns 5.
REQ-031 Holdoff enabled with HOLDOFF_CLOCKS=16 and S_0 continuously above threshold for 40 clocks -> pulses 17 clocks apart; with the macro undefined -> a single 40-clock high level.
